// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and constants for the memory responder
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1eceb000;

    // Latency counter width; LATENCY is limited to 1..15 so it fits.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_responder_array.sv
// rtl/mem_responder_array.sv - single-port word store with byte write enables and registered read
module mem_responder_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // One access per cycle: byte-masked write when any we bit is set, otherwise a registered read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (|we) begin
                for (int b = 0; b < 4; b++) begin
                    if (we[b]) begin
                        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency single-outstanding memory responder
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 3,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [3:0]  rmask,
    input  logic [3:0]  wmask,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        resp,
    output logic        error,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              error_q, error_d;
    logic              accept;

    logic [31:0]       addr_q;
    logic [3:0]        rmask_q;
    logic [3:0]        wmask_q;
    logic [31:0]       wdata_q;
    logic [AW-1:0]     idx_q;
    logic              ok_q;

    logic              req_valid;
    logic [31:0]       offset;
    logic [31:0]       word_idx;
    logic              req_ok;

    logic              arr_en;
    logic [3:0]        arr_we;
    logic [31:0]       arr_rdata;

    // Request decode: word index is unsigned, so addresses below BASE_ADDR wrap out of range.
    always_comb begin
        req_valid = (|rmask) || (|wmask);
        offset    = addr - BASE_ADDR;
        word_idx  = offset >> 2;
        req_ok    = !((|rmask) && (|wmask)) && (addr[1:0] == 2'b00)
                    && (word_idx < 32'(DEPTH_WORDS));
    end

    // Next-state, counter, sticky error and storage access control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        error_d = error_q;
        accept  = 1'b0;
        arr_en  = 1'b0;
        arr_we  = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if ({addr, rmask, wmask, wdata} != {addr_q, rmask_q, wmask_q, wdata_q}) begin
                    error_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    // Fetch on the last wait cycle so the registered word lands in the resp cycle.
                    arr_en  = ok_q && (|rmask_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                // Write commits on the edge leaving RESP; a reset on that edge abandons it.
                if (ok_q && rst) begin
                    arr_we = wmask_q;
                    arr_en = |wmask_q;
                end
                // A request already presented during resp is taken immediately for full throughput.
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (accept && !req_ok) begin
            error_d = 1'b1;
        end
    end

    // State, counter, error flag and captured request registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            error_q <= 1'b0;
            addr_q  <= '0;
            rmask_q <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
            if (accept) begin
                addr_q  <= addr;
                rmask_q <= rmask;
                wmask_q <= wmask;
                wdata_q <= wdata;
                idx_q   <= word_idx[AW-1:0];
                ok_q    <= req_ok;
            end
        end
    end

    mem_responder_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // Outputs: read data only appears for a good read during its resp cycle.
    always_comb begin
        resp  = (state_q == ST_RESP);
        busy  = (state_q == ST_WAIT);
        error = error_q;
        rdata = (resp && ok_q && (|rmask_q)) ? arr_rdata : 32'h0;
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

    localparam logic [31:0] B    = 32'h1eceb000;
    localparam int          LAT0 = 3;

    logic        clk;
    logic        rst;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  rmask0, wmask0;
    logic        resp0, error0, busy0;
    logic [31:0] addr1, wdata1, rdata1;
    logic [3:0]  rmask1, wmask1;
    logic        resp1, error1, busy1;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT0), .BASE_ADDR(B)) dut0 (
        .clk(clk), .rst(rst), .addr(addr0), .rmask(rmask0), .wmask(wmask0), .wdata(wdata0),
        .rdata(rdata0), .resp(resp0), .error(error0), .busy(busy0)
    );

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(B)) dut1 (
        .clk(clk), .rst(rst), .addr(addr1), .rmask(rmask1), .wmask(wmask1), .wdata(wdata1),
        .rdata(rdata1), .resp(resp1), .error(error1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear0();
        addr0 = '0; rmask0 = '0; wmask0 = '0; wdata0 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear0();
        addr1 = '0; rmask1 = '0; wmask1 = '0; wdata1 = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // One transaction on dut0, inputs held through edge T+LAT0 and dropped in the resp cycle.
    task automatic req0(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input string nm);
        logic early;
        early = 1'b0;
        addr0 = a; rmask0 = rm; wmask0 = wm; wdata0 = wd;
        for (int i = 0; i < LAT0; i++) begin
            tick();
            if (resp0 !== 1'b0 || busy0 !== 1'b1) early = 1'b1;
        end
        tick();
        chk({nm, " wait_phase"}, {31'b0, early}, 32'h0);
        chk({nm, " resp"}, {31'b0, resp0}, 32'h1);
        chk({nm, " rdata"}, rdata0, exp_rd);
        chk({nm, " error"}, {31'b0, error0}, {31'b0, exp_err});
        clear0();
        tick();
        chk({nm, " idle_after"}, {resp0, busy0, rdata0[29:0]}, 32'h0);
    endtask

    initial begin
        logic        bad;
        int          cnt;
        vecs[0]  = '{B + 32'h008, 4'h0, 4'hf, 32'hdeadbeef, 32'h0,        1'b0};
        vecs[1]  = '{B + 32'h008, 4'hf, 4'h0, 32'h0,        32'hdeadbeef, 1'b0};
        vecs[2]  = '{B + 32'h00c, 4'h0, 4'hf, 32'h11223344, 32'h0,        1'b0};
        vecs[3]  = '{B + 32'h00c, 4'h0, 4'h2, 32'h0000aa00, 32'h0,        1'b0};
        vecs[4]  = '{B + 32'h00c, 4'hf, 4'h0, 32'h0,        32'h1122aa44, 1'b0};
        vecs[5]  = '{B + 32'h000, 4'h0, 4'hf, 32'ha5a5a5a5, 32'h0,        1'b0};
        vecs[6]  = '{B + 32'h000, 4'h0, 4'h9, 32'h11ffff22, 32'h0,        1'b0};
        vecs[7]  = '{B + 32'h000, 4'hf, 4'h0, 32'h0,        32'h11a5a522, 1'b0};
        vecs[8]  = '{B + 32'hffc, 4'h0, 4'hf, 32'h0badf00d, 32'h0,        1'b0};
        vecs[9]  = '{B + 32'hffc, 4'hf, 4'h0, 32'h0,        32'h0badf00d, 1'b0};
        vecs[10] = '{B + 32'h014, 4'h0, 4'hf, 32'h00000000, 32'h0,        1'b0};
        vecs[11] = '{B + 32'h008, 4'h1, 4'h0, 32'h0,        32'hdeadbeef, 1'b0};

        do_reset();
        chk("reset dut0", {28'b0, resp0, busy0, error0, |rdata0}, 32'h0);
        chk("reset dut1", {28'b0, resp1, busy1, error1, |rdata1}, 32'h0);

        for (int v = 0; v < 12; v++) begin
            req0(vecs[v].a, vecs[v].rm, vecs[v].wm, vecs[v].wd, vecs[v].exp_rd, vecs[v].exp_err,
                 $sformatf("vec%0d", v));
        end

        // Misaligned request: resp still pulses, error sticks through 100 idle cycles.
        req0(B + 32'h2, 4'hf, 4'h0, 32'h0, 32'h0, 1'b1, "misaligned");
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (error0 !== 1'b1 || resp0 !== 1'b0) bad = 1'b1;
        end
        chk("error_sticky", {31'b0, bad}, 32'h0);
        do_reset();
        chk("error_cleared_by_reset", {31'b0, error0}, 32'h0);

        // Illegal requests: no write, rdata zero. Truncated indices would alias words 0 and 1023.
        req0(B + 32'h1000, 4'h0, 4'hf, 32'h55555555, 32'h0, 1'b1, "oor_high_write");
        req0(B - 32'h4,    4'h0, 4'hf, 32'h66666666, 32'h0, 1'b1, "below_base_write");
        req0(B + 32'h1000, 4'hf, 4'h0, 32'h0,        32'h0, 1'b1, "oor_high_read");
        req0(B + 32'h008,  4'hf, 4'hf, 32'h0,        32'h0, 1'b1, "both_masks");
        do_reset();
        req0(B + 32'h000, 4'hf, 4'h0, 32'h0, 32'h11a5a522, 1'b0, "word0_intact");
        req0(B + 32'hffc, 4'hf, 4'h0, 32'h0, 32'h0badf00d, 1'b0, "word1023_intact");
        req0(B + 32'h008, 4'hf, 4'h0, 32'h0, 32'hdeadbeef, 1'b0, "word2_intact");

        // Address changes mid-wait: error set, original address written.
        addr0 = B + 32'h010; rmask0 = 4'h0; wmask0 = 4'hf; wdata0 = 32'h12345678;
        tick();
        addr0 = B + 32'h014;
        tick();
        tick();
        chk("change_err", {31'b0, error0}, 32'h1);
        tick();
        chk("change_resp", {31'b0, resp0}, 32'h1);
        clear0();
        tick();
        do_reset();
        req0(B + 32'h010, 4'hf, 4'h0, 32'h0, 32'h12345678, 1'b0, "change_orig");
        req0(B + 32'h014, 4'hf, 4'h0, 32'h0, 32'h00000000, 1'b0, "change_other");

        // Reset during wait of a write: abandoned, no resp, old value kept.
        addr0 = B + 32'h008; rmask0 = 4'h0; wmask0 = 4'hf; wdata0 = 32'hffffffff;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        clear0();
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (resp0 !== 1'b0 || busy0 !== 1'b0) bad = 1'b1;
            tick();
        end
        chk("abandon_no_resp", {31'b0, bad}, 32'h0);
        req0(B + 32'h008, 4'hf, 4'h0, 32'h0, 32'hdeadbeef, 1'b0, "abandon_old");

        // LATENCY=1: seed a word, then ten back-to-back reads.
        addr1 = B; rmask1 = 4'h0; wmask1 = 4'hf; wdata1 = 32'hcafef00d;
        tick();
        chk("l1_write_busy", {31'b0, busy1}, 32'h1);
        tick();
        chk("l1_write_resp", {31'b0, resp1}, 32'h1);
        wmask1 = 4'h0; wdata1 = 32'h0;
        tick();
        rmask1 = 4'hf;
        bad = 1'b0;
        cnt = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (resp1 === 1'b1) cnt++;
            if (k < 20) begin
                if ((k % 2) == 0) begin
                    if (busy1 !== 1'b1 || resp1 !== 1'b0) bad = 1'b1;
                end else begin
                    if (busy1 !== 1'b0 || resp1 !== 1'b1 || rdata1 !== 32'hcafef00d) bad = 1'b1;
                end
            end else begin
                if (busy1 !== 1'b0 || resp1 !== 1'b0 || rdata1 !== 32'h0) bad = 1'b1;
            end
            if (k == 19) rmask1 = 4'h0;
        end
        chk("l1_resp_count", cnt, 32'd10);
        chk("l1_pattern", {31'b0, bad}, 32'h0);
        chk("l1_no_error", {31'b0, error1}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
